// File: rtl/driver_real_ramp.sv
// driver_real_ramp: drives one real-valued analog node from a digital controller.
// A command (target, step count) is accepted over a valid/ready handshake; the
// output then moves to the clamped target in a linear ramp of N clock steps, or
// jumps immediately when N is zero. The last step always lands exactly on the
// target so no accumulated rounding error is left on the node.
//
// Ports:
//   clk_i           sole clock, rising edge
//   rst_i           asynchronous active-high reset
//   req_valid_i     command valid
//   req_ready_o     block can accept a command (high in IDLE)
//   req_target_i    commanded final value
//   req_steps_i     number of clock steps in the ramp (0 = jump)
//   abort_i         stop an active ramp and hold the present value
//   driven_value_o  value applied to the analog node (registered)
//   busy_o          ramp in progress
//   done_o          one-cycle pulse when the node reaches the target
//   clamped_o       one-cycle pulse when the accepted target was clamped
module driver_real_ramp #(
    parameter real         RESET_VALUE = 0.0,
    parameter real         MIN_VALUE   = -1.0e3,
    parameter real         MAX_VALUE   = 1.0e3,
    parameter int unsigned STEPS_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  real                req_target_i,
    input  logic [STEPS_W-1:0] req_steps_i,
    input  logic               abort_i,
    output real                driven_value_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               clamped_o
);

    typedef enum logic [0:0] {StIdle, StRamp} state_e;

    state_e             state_q;
    real                value_q;
    real                tgt_q;
    real                inc_q;
    logic [STEPS_W-1:0] cnt_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               clamped_q;

    // Clamped form of the incoming target, evaluated only at accept time.
    real  tgt_c;
    logic clamp_hit;

    always_comb begin
        tgt_c     = req_target_i;
        clamp_hit = 1'b0;
        if (req_target_i > MAX_VALUE) begin
            tgt_c     = MAX_VALUE;
            clamp_hit = 1'b1;
        end else if (req_target_i < MIN_VALUE) begin
            tgt_c     = MIN_VALUE;
            clamp_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            value_q   <= RESET_VALUE;
            tgt_q     <= RESET_VALUE;
            inc_q     <= 0.0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // abort is ignored here; a concurrent request still wins.
                    if (req_valid_i) begin
                        tgt_q     <= tgt_c;
                        clamped_q <= clamp_hit;
                        if (req_steps_i == '0) begin
                            value_q <= tgt_c;
                            done_q  <= 1'b1;
                        end else begin
                            inc_q   <= (tgt_c - value_q) / real'(req_steps_i);
                            cnt_q   <= req_steps_i;
                            state_q <= StRamp;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StRamp: begin
                    if (abort_i) begin
                        // Freeze the node where it is; no completion reported.
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == STEPS_W'(1)) begin
                        // Snap to the stored target to discard rounding drift.
                        value_q <= tgt_q;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        value_q <= value_q + inc_q;
                        cnt_q   <= cnt_q - STEPS_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o    = ready_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign clamped_o      = clamped_q;
    assign driven_value_o = value_q;

endmodule

// File: tb/tb_driver_real_ramp.sv
// Testbench for driver_real_ramp: table of per-cycle vectors plus a hand-written
// reset-mid-ramp sequence. Inputs change 1 time unit after each rising edge and
// outputs are sampled at the same point, after the edge has settled.
module tb_driver_real_ramp;

    localparam int unsigned STEPS_W = 16;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    real                req_target;
    logic [STEPS_W-1:0] req_steps;
    logic               abort;
    real                driven_value;
    logic               busy;
    logic               done;
    logic               clamped;

    int checks = 0;
    int errors = 0;

    driver_real_ramp #(
        .RESET_VALUE(0.0),
        .MIN_VALUE  (-1.0e3),
        .MAX_VALUE  (1.0e3),
        .STEPS_W    (STEPS_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_target_i  (req_target),
        .req_steps_i   (req_steps),
        .abort_i       (abort),
        .driven_value_o(driven_value),
        .busy_o        (busy),
        .done_o        (done),
        .clamped_o     (clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               valid;
        real                target;
        logic [STEPS_W-1:0] steps;
        logic               abrt;
        real                exp_value;
        logic               exp_busy;
        logic               exp_done;
        logic               exp_clamped;
        logic               exp_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input real t, input int s, input logic a,
                       input real ev, input logic eb, input logic ed, input logic ec,
                       input logic er);
        vec_t x;
        x.valid       = v;
        x.target      = t;
        x.steps       = STEPS_W'(s);
        x.abrt        = a;
        x.exp_value   = ev;
        x.exp_busy    = eb;
        x.exp_done    = ed;
        x.exp_clamped = ec;
        x.exp_ready   = er;
        vecs.push_back(x);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_real(input string name, input real act, input real exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %f expected %f", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input real ev, input logic eb,
                             input logic ed, input logic ec, input logic er);
        check_real({tag, " value"}, driven_value, ev);
        check_bit({tag, " busy"}, busy, eb);
        check_bit({tag, " done"}, done, ed);
        check_bit({tag, " clamped"}, clamped, ec);
        check_bit({tag, " ready"}, req_ready, er);
    endtask

    task automatic drive(input logic v, input real t, input int s, input logic a);
        req_valid  = v;
        req_target = t;
        req_steps  = STEPS_W'(s);
        abort      = a;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 0.0, 0, 1'b0);

        // Columns: valid target steps abort | value busy done clamped ready
        // Ramp 0 -> 1.0 in 4 steps.
        add(1, 1.0, 4, 0,    0.0,  1, 0, 0, 0);
        add(0, 0.0, 0, 0,    0.25, 1, 0, 0, 0);
        add(0, 0.0, 0, 0,    0.5,  1, 0, 0, 0);
        add(0, 0.0, 0, 0,    0.75, 1, 0, 0, 0);
        add(0, 0.0, 0, 0,    1.0,  0, 1, 0, 1);
        add(0, 0.0, 0, 0,    1.0,  0, 0, 0, 1);
        // Jump to -2.5.
        add(1, -2.5, 0, 0,   -2.5, 0, 1, 0, 1);
        add(0, 0.0, 0, 0,    -2.5, 0, 0, 0, 1);
        // Clamped ramp toward 5000 -> 1000 in 2 steps, increment 501.25.
        add(1, 5000.0, 2, 0, -2.5,   1, 0, 1, 0);
        add(0, 0.0, 0, 0,    498.75, 1, 0, 0, 0);
        add(0, 0.0, 0, 0,    1000.0, 0, 1, 0, 1);
        // Negative clamp on a jump.
        add(1, -7000.0, 0, 0, -1000.0, 0, 1, 1, 1);
        // Back to 0, then ramp to 10 in 10 steps and abort at 3.0.
        add(1, 0.0, 0, 0,    0.0, 0, 1, 0, 1);
        add(1, 10.0, 10, 0,  0.0, 1, 0, 0, 0);
        add(0, 0.0, 0, 0,    1.0, 1, 0, 0, 0);
        add(0, 0.0, 0, 0,    2.0, 1, 0, 0, 0);
        add(0, 0.0, 0, 0,    3.0, 1, 0, 0, 0);
        add(0, 0.0, 0, 1,    3.0, 0, 0, 0, 1);
        add(0, 0.0, 0, 0,    3.0, 0, 0, 0, 1);
        // Abort alone in IDLE is ignored.
        add(0, 0.0, 0, 1,    3.0, 0, 0, 0, 1);
        // Abort together with a request in IDLE: request accepted.
        add(1, 5.0, 2, 1,    3.0, 1, 0, 0, 0);
        add(0, 0.0, 0, 0,    4.0, 1, 0, 0, 0);
        add(0, 0.0, 0, 0,    5.0, 0, 1, 0, 1);
        // Target equal to current value still takes N cycles.
        add(1, 5.0, 2, 0,    5.0, 1, 0, 0, 0);
        add(0, 0.0, 0, 0,    5.0, 1, 0, 0, 0);
        add(0, 0.0, 0, 0,    5.0, 0, 1, 0, 1);
        // Backpressure: second command (9.0, 1 step) held during a ramp to 7.
        add(1, 7.0, 2, 0,    5.0, 1, 0, 0, 0);
        add(1, 9.0, 1, 0,    6.0, 1, 0, 0, 0);
        add(1, 9.0, 1, 0,    7.0, 0, 1, 0, 1);
        add(1, 9.0, 1, 0,    7.0, 1, 0, 0, 0);
        add(0, 0.0, 0, 0,    9.0, 0, 1, 0, 1);
        // Return to 0 for the reset-mid-ramp sequence.
        add(1, 0.0, 0, 0,    0.0, 0, 1, 0, 1);
        add(0, 0.0, 0, 0,    0.0, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all("reset", 0.0, 1'b0, 1'b0, 1'b0, 1'b1);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].target, int'(vecs[i].steps), vecs[i].abrt);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_value, vecs[i].exp_busy,
                      vecs[i].exp_done, vecs[i].exp_clamped, vecs[i].exp_ready);
        end

        // Reset mid-ramp: 0 -> 8 in 8 steps, reset when the value is 4.0.
        drive(1'b1, 8.0, 8, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 0.0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_all("midramp", 4.0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_real("rst_async value", driven_value, 0.0);
        check_bit("rst_async busy", busy, 1'b0);
        check_bit("rst_async done", done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst", 0.0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2.0, 2, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 0.0, 0, 1'b0);
        check_all("post_rst acc", 0.0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("post_rst s1", 1.0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("post_rst s2", 2.0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/driver_real_ramp.md
# driver_real_ramp

Stimulus-side counterpart to the real-value observer: drives one `real` analog node from a digital testbench controller, moving it to commanded targets with a linear, step-counted ramp instead of an instantaneous jump. Sits between a UVM driver or sequencer-facing register model and the analog DUT input. Accepts one ramp command at a time over a valid/ready handshake and reports completion. Its `driven_value` output is the net that a real observer monitors.

## Interface
- `RESET_VALUE`, 0.0: real value driven during and after reset.
- `MIN_VALUE`, -1.0e3: lower clamp applied to commanded targets.
- `MAX_VALUE`, 1.0e3: upper clamp applied to commanded targets.
- `STEPS_W`, 16: width of the step-count field.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  block can accept a command.
- `req_target`  in  real  commanded final value.
- `req_steps`  in  STEPS_W  number of clock steps in the ramp (0 = jump).
- `abort`  in  1  stop ramp and hold current value.
- `driven_value`  out  real  value applied to the analog node.
- `busy`  out  1  ramp in progress.
- `done`  out  1  one-cycle pulse when `driven_value` reaches target.
- `clamped`  out  1  one-cycle pulse when accepted target was clamped.

## Operation
- States: IDLE, RAMP.
- IDLE: `req_ready`=1, `busy`=0. `driven_value` holds.
- Accept happens when `req_valid && req_ready` on a rising edge.
  - Target is clamped to [MIN_VALUE, MAX_VALUE] and stored as `tgt`.
  - `clamped` pulses on the next cycle if clamping changed the value.
  - `req_steps`=0: `driven_value`<=`tgt`, `done` pulses, stay IDLE.
  - `req_steps`=N>0: latch `inc`=(`tgt`-`driven_value`)/N, `cnt`<=N, go to RAMP.
- RAMP: `req_ready`=0, `busy`=1. Each cycle, `driven_value`+=`inc` and `cnt`-=1.
- Final step (`cnt`==1): `driven_value`<=`tgt` exactly, with no accumulated float error. `done` pulses, return to IDLE.
- `abort` in RAMP takes effect next edge: return to IDLE, hold the current `driven_value`, no `done`. `abort` in IDLE is ignored.
- `abort` and `req_valid` in the same IDLE cycle: the request is accepted; `abort` is ignored.
- A target equal to the current value with N>0 still takes N cycles and pulses `done`.
- `req_valid` while `req_ready`=0 is not consumed; the requester holds it until accepted.

## Timing
- Reset (async assert): state=IDLE, `driven_value`=RESET_VALUE, `busy`=0, `done`=0, `clamped`=0, `req_ready`=1 (after deassert), `cnt`=0, `inc`=0.0.
- Reset mid-ramp: immediate return to RESET_VALUE. No `done` is produced.
- Latency, accept edge to final value:
  - N=0: value is final at the accept edge; `done` is high in the cycle after that edge.
  - N>0: value is final N edges after the accept edge. `done` is high in the cycle following the final-value edge.
- The first ramp increment appears one edge after the accept edge.
- `req_ready` returns to 1 in the same cycle `done` is high, so back-to-back commands are accepted every N+1 cycles.
- `clamped` is high in the cycle after the accept edge.
- No combinational path from inputs to `driven_value`.

## Test plan
- Reset, then ramp: after reset, `driven_value`=0.0. Request target 1.0, steps 4 → values 0.25, 0.5, 0.75, 1.0 on successive edges; `done` pulses once; `busy` high for 4 cycles.
- Jump: from 1.0, request -2.5, steps 0 → `driven_value`=-2.5 the next cycle, `done` pulses, `busy` never asserted.
- Clamp: request 5000.0, steps 2 → `clamped` pulses. The ramp ends exactly at 1000.0.
- Abort: ramp 0.0→10.0 in 10 steps; assert `abort` after the 3rd increment (value 3.0) → value holds 3.0, no `done`, `req_ready`=1 next cycle.
- Backpressure and back-to-back: hold `req_valid` with a second command during a ramp → not accepted until `done`. It is then accepted, and its first step appears the cycle after.
- Reset mid-ramp: assert `rst` during a ramp 0→8 at value 4.0 → `driven_value`=0.0 immediately, `busy`=0. After deassert, a new request proceeds normally.
